// File: rtl/pipe_ctrl_unit.sv
// ID-stage decoder and pipeline control-bit registers for the 5-stage MIPS core.
// Detects load-use and branch-operand hazards, inserts bubbles, and honours an external freeze.
module pipe_ctrl_unit #(
  parameter int REG_AW           = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int BRANCH_IN_ID     = 1,
  parameter int SUPPORT_BNE      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_ext,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_funct,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_eq,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              pc_src,
  output logic              jump,
  output logic              jump_r,
  output logic              if_flush,
  output logic              ex_alu_src,
  output logic [1:0]        ex_alu_op,
  output logic              ex_reg_dst,
  output logic              ex_ra_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;
  localparam logic [REG_AW-1:0] REG_RA   = REG_AW'(31);

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       ra_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  ctrl_t             id_ctrl;
  logic              id_legal;
  logic              id_is_beq;
  logic              id_is_bne;
  logic              id_is_jump;
  logic              id_is_jr;
  logic              id_reads_rs;
  logic              id_reads_rt;
  logic [REG_AW-1:0] id_dest;

  ctrl_t             idex_ctrl;
  logic [REG_AW-1:0] idex_dest;
  logic              exmem_mem_read;
  logic              exmem_mem_write;
  logic              exmem_reg_write;
  logic              exmem_mem_to_reg;
  logic [REG_AW-1:0] exmem_dest;
  logic              memwb_reg_write;
  logic              memwb_mem_to_reg;
  logic              illegal_q;

  logic ex_load;
  logic ex_write;
  logic mem_load;
  logic rs_ex_match;
  logic rt_ex_match;
  logic rs_mem_match;
  logic rt_mem_match;
  logic id_branch_rs;
  logic id_branch_rt;
  logic load_use_hazard;
  logic branch_hazard;
  logic hazard;
  logic redirect_ok;

  // An invalid IF/ID slot leaves every decode output at its bubble default.
  always_comb begin
    id_ctrl     = '0;
    id_legal    = 1'b1;
    id_is_beq   = 1'b0;
    id_is_bne   = 1'b0;
    id_is_jump  = 1'b0;
    id_is_jr    = 1'b0;
    id_reads_rs = 1'b0;
    id_reads_rt = 1'b0;
    if (id_valid) begin
      case (id_op)
        OP_RTYPE: begin
          id_ctrl.alu_op  = 2'b10;
          id_ctrl.reg_dst = 1'b1;
          id_reads_rs     = 1'b1;
          id_reads_rt     = 1'b1;
          if (id_funct == FN_JR) begin
            id_is_jr = 1'b1;
          end else begin
            id_ctrl.reg_write = 1'b1;
            if (id_funct == FN_JALR) begin
              id_is_jr         = 1'b1;
              id_ctrl.ra_write = 1'b1;
            end
          end
        end
        OP_BEQ: begin
          id_ctrl.alu_op = 2'b01;
          id_is_beq      = 1'b1;
          id_reads_rs    = 1'b1;
          id_reads_rt    = 1'b1;
        end
        OP_BNE: begin
          if (SUPPORT_BNE != 0) begin
            id_ctrl.alu_op = 2'b01;
            id_is_bne      = 1'b1;
            id_reads_rs    = 1'b1;
            id_reads_rt    = 1'b1;
          end else begin
            id_legal = 1'b0;
          end
        end
        OP_J: begin
          id_is_jump = 1'b1;
        end
        OP_JAL: begin
          id_is_jump        = 1'b1;
          id_ctrl.ra_write  = 1'b1;
          id_ctrl.reg_write = 1'b1;
        end
        OP_LW: begin
          id_ctrl.alu_src    = 1'b1;
          id_ctrl.mem_read   = 1'b1;
          id_ctrl.reg_write  = 1'b1;
          id_ctrl.mem_to_reg = 1'b1;
          id_reads_rs        = 1'b1;
        end
        OP_SW: begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.mem_write = 1'b1;
          id_reads_rs       = 1'b1;
          id_reads_rt       = 1'b1;
        end
        OP_ADDI, OP_SLTI: begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.alu_op    = (id_op == OP_SLTI) ? 2'b01 : 2'b00;
          id_ctrl.reg_write = 1'b1;
          id_reads_rs       = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.alu_op    = 2'b11;
          id_ctrl.reg_write = 1'b1;
          id_reads_rs       = 1'b1;
        end
        default: begin
          id_legal = 1'b0;
        end
      endcase
    end
  end

  // jalr sets both reg_dst and ra_write, so rd must win over $31 here.
  assign id_dest = id_ctrl.reg_dst  ? id_rd :
                   id_ctrl.ra_write ? REG_RA : id_rt;

  assign ex_load  = idex_ctrl.mem_read  && (idex_dest != REG_ZERO);
  assign ex_write = idex_ctrl.reg_write && (idex_dest != REG_ZERO);
  assign mem_load = exmem_mem_read      && (exmem_dest != REG_ZERO);

  assign rs_ex_match  = (id_rs == idex_dest);
  assign rt_ex_match  = (id_rt == idex_dest);
  assign rs_mem_match = (id_rs == exmem_dest);
  assign rt_mem_match = (id_rt == exmem_dest);

  assign id_branch_rs = id_is_beq || id_is_bne || id_is_jr;
  assign id_branch_rt = id_is_beq || id_is_bne;

  // Without MEM->EX forwarding a load two ahead still cannot feed EX in time.
  assign load_use_hazard =
      (ex_load && ((id_reads_rs && rs_ex_match) || (id_reads_rt && rt_ex_match))) ||
      ((LOAD_USE_BUBBLES >= 2) && mem_load &&
       ((id_reads_rs && rs_mem_match) || (id_reads_rt && rt_mem_match)));

  // ID-resolved branches compare raw register values, so any in-flight EX result is too late.
  assign branch_hazard = (BRANCH_IN_ID != 0) && (
      (id_branch_rs && ((ex_write && rs_ex_match) || (mem_load && rs_mem_match))) ||
      (id_branch_rt && ((ex_write && rt_ex_match) || (mem_load && rt_mem_match))));

  assign hazard = load_use_hazard || branch_hazard;

  assign redirect_ok = rst_n && !stall_ext && !hazard;
  assign pc_write    = !rst_n || (!stall_ext && !hazard);
  assign ifid_write  = pc_write;
  assign pc_src      = redirect_ok && ((id_is_beq && id_eq) || (id_is_bne && !id_eq));
  assign jump        = redirect_ok && id_is_jump;
  assign jump_r      = redirect_ok && id_is_jr;
  assign if_flush    = pc_src || jump || jump_r;

  // Stage registers: an external stall freezes all three, a hazard only bubbles ID/EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl        <= '0;
      idex_dest        <= '0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_dest       <= '0;
      memwb_reg_write  <= 1'b0;
      memwb_mem_to_reg <= 1'b0;
    end else if (!stall_ext) begin
      if (hazard) begin
        idex_ctrl <= '0;
        idex_dest <= '0;
      end else begin
        idex_ctrl <= id_ctrl;
        idex_dest <= id_dest;
      end
      exmem_mem_read   <= idex_ctrl.mem_read;
      exmem_mem_write  <= idex_ctrl.mem_write;
      exmem_reg_write  <= idex_ctrl.reg_write;
      exmem_mem_to_reg <= idex_ctrl.mem_to_reg;
      exmem_dest       <= idex_dest;
      memwb_reg_write  <= exmem_reg_write;
      memwb_mem_to_reg <= exmem_mem_to_reg;
    end
  end

  // Sticky until reset; a frozen pipeline has not really consumed the opcode yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (!stall_ext && id_valid && !id_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign ex_alu_src    = idex_ctrl.alu_src;
  assign ex_alu_op     = idex_ctrl.alu_op;
  assign ex_reg_dst    = idex_ctrl.reg_dst;
  assign ex_ra_write   = idex_ctrl.ra_write;
  assign mem_mem_read  = exmem_mem_read;
  assign mem_mem_write = exmem_mem_write;
  assign wb_reg_write  = memwb_reg_write;
  assign wb_mem_to_reg = memwb_mem_to_reg;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two configurations driven from directed programs and random
// instruction streams, compared every cycle against an instruction-kind level model.
module tb_pipe_ctrl_unit;

  typedef enum int {K_NOP, K_R, K_JR, K_JALR, K_BEQ, K_BNE, K_J, K_JAL,
                    K_LW, K_SW, K_ADDI, K_SLTI, K_LOGI, K_ILL} kind_e;

  typedef struct {
    bit       v;
    bit [5:0] op;
    bit [5:0] funct;
    bit [4:0] rs;
    bit [4:0] rt;
    bit [4:0] rd;
    bit       eq;
  } instr_t;

  logic clk;
  logic rst_n;
  logic stall_ext;
  logic [1:0]      id_valid;
  logic [1:0][5:0] id_op;
  logic [1:0][5:0] id_funct;
  logic [1:0][4:0] id_rs;
  logic [1:0][4:0] id_rt;
  logic [1:0][4:0] id_rd;
  logic [1:0]      id_eq;
  logic [1:0]      pc_write, ifid_write, pc_src, jump, jump_r, if_flush;
  logic [1:0]      ex_alu_src, ex_reg_dst, ex_ra_write;
  logic [1:0][1:0] ex_alu_op;
  logic [1:0]      mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, illegal_op;

  int total = 0;
  int bad = 0;

  int  bubCfg [2] = '{1, 2};
  bit  bneCfg [2] = '{0, 1};

  kind_e exK [2], memK [2], wbK [2], idK [2];
  int    exD [2], memD [2], idD [2];
  bit    illM [2];
  bit    expHaz [2], expPcw [2], expPcSrc [2], expJump [2], expJr [2], expFlush [2];

  instr_t cur [2];
  instr_t prog [$];
  int     pidx [2];
  bit     advance [2];
  bit     rndMode;
  int     stallCnt [2], pcSrcCnt [2], jumpCnt [2];

  pipe_ctrl_unit u0 (
    .clk(clk), .rst_n(rst_n), .stall_ext(stall_ext),
    .id_valid(id_valid[0]), .id_op(id_op[0]), .id_funct(id_funct[0]),
    .id_rs(id_rs[0]), .id_rt(id_rt[0]), .id_rd(id_rd[0]), .id_eq(id_eq[0]),
    .pc_write(pc_write[0]), .ifid_write(ifid_write[0]), .pc_src(pc_src[0]),
    .jump(jump[0]), .jump_r(jump_r[0]), .if_flush(if_flush[0]),
    .ex_alu_src(ex_alu_src[0]), .ex_alu_op(ex_alu_op[0]), .ex_reg_dst(ex_reg_dst[0]),
    .ex_ra_write(ex_ra_write[0]), .mem_mem_read(mem_mem_read[0]),
    .mem_mem_write(mem_mem_write[0]), .wb_reg_write(wb_reg_write[0]),
    .wb_mem_to_reg(wb_mem_to_reg[0]), .illegal_op(illegal_op[0])
  );

  pipe_ctrl_unit #(.REG_AW(5), .LOAD_USE_BUBBLES(2), .BRANCH_IN_ID(1), .SUPPORT_BNE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .stall_ext(stall_ext),
    .id_valid(id_valid[1]), .id_op(id_op[1]), .id_funct(id_funct[1]),
    .id_rs(id_rs[1]), .id_rt(id_rt[1]), .id_rd(id_rd[1]), .id_eq(id_eq[1]),
    .pc_write(pc_write[1]), .ifid_write(ifid_write[1]), .pc_src(pc_src[1]),
    .jump(jump[1]), .jump_r(jump_r[1]), .if_flush(if_flush[1]),
    .ex_alu_src(ex_alu_src[1]), .ex_alu_op(ex_alu_op[1]), .ex_reg_dst(ex_reg_dst[1]),
    .ex_ra_write(ex_ra_write[1]), .mem_mem_read(mem_mem_read[1]),
    .mem_mem_write(mem_mem_write[1]), .wb_reg_write(wb_reg_write[1]),
    .wb_mem_to_reg(wb_mem_to_reg[1]), .illegal_op(illegal_op[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic kind_e classify(instr_t x, bit bneOk);
    kind_e k;
    if (!x.v) return K_NOP;
    case (x.op)
      6'h00: k = (x.funct == 6'h08) ? K_JR : (x.funct == 6'h09) ? K_JALR : K_R;
      6'h04: k = K_BEQ;
      6'h05: k = bneOk ? K_BNE : K_ILL;
      6'h02: k = K_J;
      6'h03: k = K_JAL;
      6'h23: k = K_LW;
      6'h2B: k = K_SW;
      6'h08: k = K_ADDI;
      6'h0A: k = K_SLTI;
      6'h0C, 6'h0D, 6'h0E: k = K_LOGI;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  // {alu_src, alu_op[1:0], reg_dst, ra_write, mem_read, mem_write, reg_write, mem_to_reg}
  function automatic logic [8:0] ctrlOf(kind_e k);
    case (k)
      K_R:          return 9'b0_10_1_0_0_0_1_0;
      K_JR:         return 9'b0_10_1_0_0_0_0_0;
      K_JALR:       return 9'b0_10_1_1_0_0_1_0;
      K_BEQ, K_BNE: return 9'b0_01_0_0_0_0_0_0;
      K_JAL:        return 9'b0_00_0_1_0_0_1_0;
      K_LW:         return 9'b1_00_0_0_1_0_1_1;
      K_SW:         return 9'b1_00_0_0_0_1_0_0;
      K_ADDI:       return 9'b1_00_0_0_0_0_1_0;
      K_SLTI:       return 9'b1_01_0_0_0_0_1_0;
      K_LOGI:       return 9'b1_11_0_0_0_0_1_0;
      default:      return 9'b0;
    endcase
  endfunction

  function automatic int destOf(kind_e k, instr_t x);
    if (!(k inside {K_R, K_JALR, K_JAL, K_LW, K_ADDI, K_SLTI, K_LOGI})) return 0;
    if (k inside {K_R, K_JALR}) return int'(x.rd);
    if (k == K_JAL) return 31;
    return int'(x.rt);
  endfunction

  function automatic bit hazardOf(int i);
    kind_e k = idK[i];
    int rs = int'(cur[i].rs);
    int rt = int'(cur[i].rt);
    bit rdRs = k inside {K_R, K_JR, K_JALR, K_BEQ, K_BNE, K_LW, K_SW, K_ADDI, K_SLTI, K_LOGI};
    bit rdRt = k inside {K_R, K_JR, K_JALR, K_BEQ, K_BNE, K_SW};
    bit brRs = k inside {K_BEQ, K_BNE, K_JR, K_JALR};
    bit brRt = k inside {K_BEQ, K_BNE};
    bit exLoad = (exK[i] == K_LW) && (exD[i] != 0);
    bit memLoad = (memK[i] == K_LW) && (memD[i] != 0);
    bit lu, br;
    lu = exLoad && ((rdRs && rs == exD[i]) || (rdRt && rt == exD[i]));
    if (bubCfg[i] == 2)
      lu = lu || (memLoad && ((rdRs && rs == memD[i]) || (rdRt && rt == memD[i])));
    br = (brRs && ((exD[i] != 0 && rs == exD[i]) || (memLoad && rs == memD[i]))) ||
         (brRt && ((exD[i] != 0 && rt == exD[i]) || (memLoad && rt == memD[i])));
    return lu || br;
  endfunction

  function automatic instr_t randInstr();
    instr_t x;
    bit [5:0] ops [16] = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h02, 6'h03, 6'h23, 6'h23,
                           6'h2B, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h01, 6'h3F};
    bit [5:0] fns [5] = '{6'h20, 6'h22, 6'h08, 6'h09, 6'h2A};
    x.v     = ($urandom_range(0, 9) != 0);
    x.op    = ops[$urandom_range(0, 15)];
    x.funct = fns[$urandom_range(0, 4)];
    x.rs    = 5'($urandom_range(0, 3));
    x.rt    = 5'($urandom_range(0, 3));
    x.rd    = 5'($urandom_range(0, 3));
    x.eq    = 1'($urandom_range(0, 1));
    return x;
  endfunction

  function automatic instr_t mk(bit [5:0] op, bit [5:0] funct, int rs, int rt, int rd, bit eq);
    instr_t x;
    x.v = 1'b1; x.op = op; x.funct = funct;
    x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd); x.eq = eq;
    return x;
  endfunction

  task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task clearModel(input int i);
    exK[i] = K_NOP; memK[i] = K_NOP; wbK[i] = K_NOP;
    exD[i] = 0; memD[i] = 0; illM[i] = 1'b0;
  endtask

  task computeExpect(input int i);
    bit go;
    idK[i]    = classify(cur[i], bneCfg[i]);
    idD[i]    = destOf(idK[i], cur[i]);
    expHaz[i] = rst_n && hazardOf(i);
    expPcw[i] = !rst_n || !(stall_ext || expHaz[i]);
    go        = rst_n && !stall_ext && !expHaz[i];
    expPcSrc[i] = go && ((idK[i] == K_BEQ && cur[i].eq) || (idK[i] == K_BNE && !cur[i].eq));
    expJump[i]  = go && (idK[i] inside {K_J, K_JAL});
    expJr[i]    = go && (idK[i] inside {K_JR, K_JALR});
    expFlush[i] = expPcSrc[i] || expJump[i] || expJr[i];
  endtask

  task checkAll(input int i);
    logic [8:0] ce, cm, cw;
    ce = ctrlOf(exK[i]);
    cm = ctrlOf(memK[i]);
    cw = ctrlOf(wbK[i]);
    checkOutput($sformatf("u%0d.pc_write", i),      32'(pc_write[i]),      32'(expPcw[i]));
    checkOutput($sformatf("u%0d.ifid_write", i),    32'(ifid_write[i]),    32'(expPcw[i]));
    checkOutput($sformatf("u%0d.pc_src", i),        32'(pc_src[i]),        32'(expPcSrc[i]));
    checkOutput($sformatf("u%0d.jump", i),          32'(jump[i]),          32'(expJump[i]));
    checkOutput($sformatf("u%0d.jump_r", i),        32'(jump_r[i]),        32'(expJr[i]));
    checkOutput($sformatf("u%0d.if_flush", i),      32'(if_flush[i]),      32'(expFlush[i]));
    checkOutput($sformatf("u%0d.ex_alu_src", i),    32'(ex_alu_src[i]),    32'(ce[8]));
    checkOutput($sformatf("u%0d.ex_alu_op", i),     32'(ex_alu_op[i]),     32'(ce[7:6]));
    checkOutput($sformatf("u%0d.ex_reg_dst", i),    32'(ex_reg_dst[i]),    32'(ce[5]));
    checkOutput($sformatf("u%0d.ex_ra_write", i),   32'(ex_ra_write[i]),   32'(ce[4]));
    checkOutput($sformatf("u%0d.mem_mem_read", i),  32'(mem_mem_read[i]),  32'(cm[3]));
    checkOutput($sformatf("u%0d.mem_mem_write", i), 32'(mem_mem_write[i]), 32'(cm[2]));
    checkOutput($sformatf("u%0d.wb_reg_write", i),  32'(wb_reg_write[i]),  32'(cw[1]));
    checkOutput($sformatf("u%0d.wb_mem_to_reg", i), 32'(wb_mem_to_reg[i]), 32'(cw[0]));
    checkOutput($sformatf("u%0d.illegal_op", i),    32'(illegal_op[i]),    32'(illM[i]));
  endtask

  task stepModel(input int i);
    if (!rst_n) begin
      clearModel(i);
    end else if (!stall_ext) begin
      wbK[i]  = memK[i];
      memK[i] = exK[i];
      memD[i] = exD[i];
      exK[i]  = expHaz[i] ? K_NOP : idK[i];
      exD[i]  = expHaz[i] ? 0 : idD[i];
      if (idK[i] == K_ILL) illM[i] = 1'b1;
    end
  endtask

  task loadAndDrive();
    for (int i = 0; i < 2; i++) begin
      if (advance[i]) begin
        if (pidx[i] < prog.size()) begin
          cur[i] = prog[pidx[i]];
          pidx[i]++;
        end else if (rndMode) begin
          cur[i] = randInstr();
        end else begin
          cur[i] = '{default: 0};
        end
      end
      id_valid[i] = cur[i].v;
      id_op[i]    = cur[i].op;
      id_funct[i] = cur[i].funct;
      id_rs[i]    = cur[i].rs;
      id_rt[i]    = cur[i].rt;
      id_rd[i]    = cur[i].rd;
      id_eq[i]    = cur[i].eq;
    end
  endtask

  task checkBoth();
    for (int i = 0; i < 2; i++) begin
      computeExpect(i);
      checkAll(i);
      advance[i] = expPcw[i];
      if (pc_write[i] === 1'b0) stallCnt[i]++;
      if (pc_src[i] === 1'b1) pcSrcCnt[i]++;
      if (jump[i] === 1'b1) jumpCnt[i]++;
    end
  endtask

  // One full cycle: drive at the falling edge, check 1 ns later, advance the model on the rising edge.
  task applyStimulus(input bit se);
    stall_ext = se;
    loadAndDrive();
    #1;
    checkBoth();
    @(posedge clk);
    for (int i = 0; i < 2; i++) stepModel(i);
    @(negedge clk);
  endtask

  task startPhase();
    for (int i = 0; i < 2; i++) begin
      pidx[i] = 0; advance[i] = 1'b1;
      stallCnt[i] = 0; pcSrcCnt[i] = 0; jumpCnt[i] = 0;
    end
  endtask

  task runPhase(input int ncyc, input int seLo, input int seHi);
    startPhase();
    for (int c = 0; c < ncyc; c++) applyStimulus(c >= seLo && c < seHi);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_ext = 1'b0;
    rndMode = 1'b0;
    for (int i = 0; i < 2; i++) clearModel(i);
    prog.delete();
    startPhase();
    @(negedge clk);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("reset.pc_write_under_stall", 32'(pc_write[0]), 32'd1);
    checkOutput("reset.ex_alu_op", 32'(ex_alu_op[1]), 32'd0);
    rst_n = 1'b1;

    // lw $2 ; add $3,$2,$4 -> one bubble with forwarding, two without
    prog = '{mk(6'h23, 6'h00, 1, 2, 0, 0), mk(6'h00, 6'h20, 2, 4, 3, 0)};
    runPhase(8, -1, -1);
    checkOutput("loaduse.bubbles_u0", 32'(stallCnt[0]), 32'd1);
    checkOutput("loaduse.bubbles_u1", 32'(stallCnt[1]), 32'd2);

    // beq taken, then beq not taken
    prog = '{mk(6'h04, 6'h00, 1, 1, 0, 1), mk(6'h04, 6'h00, 1, 2, 0, 0)};
    runPhase(6, -1, -1);
    checkOutput("beq.taken_count_u0", 32'(pcSrcCnt[0]), 32'd1);
    checkOutput("beq.taken_count_u1", 32'(pcSrcCnt[1]), 32'd1);

    // addi $5 ; beq $5,$0 -> one branch-operand stall
    prog = '{mk(6'h08, 6'h00, 0, 5, 0, 0), mk(6'h04, 6'h00, 5, 0, 0, 1)};
    runPhase(8, -1, -1);
    checkOutput("brhaz.stalls_u0", 32'(stallCnt[0]), 32'd1);
    checkOutput("brhaz.stalls_u1", 32'(stallCnt[1]), 32'd1);
    checkOutput("brhaz.taken_u0", 32'(pcSrcCnt[0]), 32'd1);

    // jal held under a 3-cycle external stall
    prog = '{mk(6'h03, 6'h00, 0, 0, 0, 0)};
    runPhase(8, 0, 3);
    checkOutput("jal.jump_count_u0", 32'(jumpCnt[0]), 32'd1);
    checkOutput("jal.frozen_cycles_u0", 32'(stallCnt[0]), 32'd3);

    // opcode 0x05: illegal on u0, taken bne on u1
    prog = '{mk(6'h05, 6'h00, 1, 2, 0, 0)};
    runPhase(6, -1, -1);
    checkOutput("op05.illegal_u0", 32'(illegal_op[0]), 32'd1);
    checkOutput("op05.illegal_u1", 32'(illegal_op[1]), 32'd0);
    checkOutput("op05.bne_taken_u1", 32'(pcSrcCnt[1]), 32'd1);
    checkOutput("op05.no_redirect_u0", 32'(pcSrcCnt[0]), 32'd0);

    // reset asserted while the load-use stall is active
    prog = '{mk(6'h23, 6'h00, 1, 2, 0, 0), mk(6'h00, 6'h20, 2, 4, 3, 0)};
    startPhase();
    applyStimulus(1'b0);
    loadAndDrive();
    #1;
    checkBoth();
    checkOutput("midstall.pc_write_before", 32'(pc_write[0]), 32'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) clearModel(i);
    #1;
    checkBoth();
    checkOutput("midstall.pc_write_in_reset", 32'(pc_write[0]), 32'd1);
    checkOutput("midstall.ex_alu_src_in_reset", 32'(ex_alu_src[0]), 32'd0);
    checkOutput("midstall.illegal_cleared", 32'(illegal_op[0]), 32'd0);
    @(posedge clk);
    for (int i = 0; i < 2; i++) stepModel(i);
    @(negedge clk);
    rst_n = 1'b1;
    prog.delete();
    for (int i = 0; i < 2; i++) advance[i] = 1'b1;

    // random instruction stream with occasional external stalls
    rndMode = 1'b1;
    startPhase();
    for (int c = 0; c < 1500; c++) applyStimulus($urandom_range(0, 7) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
